// File: rtl/prince_cfb_pkg.sv
// Shared constants and FSM state encoding for the prince_cfb arbiter slice.
package prince_cfb_pkg;

   localparam int DATA_W  = 16;
   localparam int TIMER_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   always_comb begin
      logic           found;
      logic [IDX_W:0] pos;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(NUM_REQ))
            pos = pos - (IDX_W+1)'(NUM_REQ);
         if (!found && req[pos[IDX_W-1:0]]) begin
            found                  = 1'b1;
            grant[pos[IDX_W-1:0]]  = 1'b1;
            grant_idx              = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/prince_cfb_arbiter.sv
// Shares one prince_cfb core between NUM_REQ clients: round-robin grant, one job at a time,
// with a watchdog that aborts a job whose core never reports block_done.
module prince_cfb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = prince_cfb_pkg::DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [15:0]               chip_id_cfg,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_encrypt,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      rsp_err,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      core_start,
   output logic                      core_encrypt,
   output logic [15:0]               core_chip_id,
   output logic [DATA_W-1:0]         core_text,
   input  logic                      core_done,
   input  logic                      core_busy_n,
   input  logic [DATA_W-1:0]         cipher_text,
   output logic                      busy
);

   import prince_cfb_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t               state_reg;
   logic [IDX_W-1:0]     ptr_reg;
   logic [IDX_W-1:0]     win_reg;
   logic [TIMER_W-1:0]   timer_reg;
   logic [NUM_REQ-1:0]   req_ack_reg;
   logic [NUM_REQ-1:0]   rsp_valid_reg;
   logic                 rsp_err_reg;
   logic [DATA_W-1:0]    rsp_data_reg;
   logic                 core_start_reg;
   logic                 core_encrypt_reg;
   logic [DATA_W-1:0]    core_text_reg;

   logic [NUM_REQ-1:0]   grant;
   logic [IDX_W-1:0]     grant_idx;
   logic [DATA_W-1:0]    req_slice [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         ptr_reg          <= '0;
         win_reg          <= '0;
         timer_reg        <= '0;
         req_ack_reg      <= '0;
         rsp_valid_reg    <= '0;
         rsp_err_reg      <= 1'b0;
         rsp_data_reg     <= '0;
         core_start_reg   <= 1'b0;
         core_encrypt_reg <= 1'b0;
         core_text_reg    <= '0;
      end else begin
         // Pulse outputs default low; each is raised for the single cycle of its state.
         req_ack_reg    <= '0;
         rsp_valid_reg  <= '0;
         rsp_err_reg    <= 1'b0;
         core_start_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if ((|req_valid) && core_busy_n) begin
                  win_reg          <= grant_idx;
                  req_ack_reg      <= grant;
                  core_encrypt_reg <= req_encrypt[grant_idx];
                  core_text_reg    <= req_slice[grant_idx];
                  state_reg        <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               ptr_reg        <= (win_reg == IDX_W'(NUM_REQ-1)) ? '0 : win_reg + IDX_W'(1);
               core_start_reg <= 1'b1;
               state_reg      <= ST_START;
            end
            ST_START: begin
               timer_reg <= '0;
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               timer_reg <= timer_reg + TIMER_W'(1);
               if (core_done) begin
                  rsp_data_reg  <= cipher_text;
                  rsp_valid_reg <= NUM_REQ'(1) << win_reg;
                  state_reg     <= ST_RESP;
               end else if (timer_reg == TIMER_W'(TIMEOUT)) begin
                  rsp_err_reg   <= 1'b1;
                  rsp_data_reg  <= '0;
                  rsp_valid_reg <= NUM_REQ'(1) << win_reg;
                  state_reg     <= ST_RESP;
               end
            end
            ST_RESP:  state_reg <= ST_IDLE;
            default:  state_reg <= ST_IDLE;
         endcase
      end
   end

   assign req_ack      = req_ack_reg;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_err      = rsp_err_reg;
   assign rsp_data     = rsp_data_reg;
   assign core_start   = core_start_reg;
   assign core_encrypt = core_encrypt_reg;
   assign core_chip_id = chip_id_cfg;
   assign core_text    = core_text_reg;
   assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_prince_cfb_arbiter.sv
// Scoreboard bench for prince_cfb_arbiter with a behavioural stand-in for the prince_cfb core.
module tb_prince_cfb_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 255;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [15:0]               chip_id_cfg = 16'h2020;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_encrypt = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        req_ack;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic                      rsp_err;
   logic [DATA_W-1:0]         rsp_data;
   logic                      core_start;
   logic                      core_encrypt;
   logic [15:0]               core_chip_id;
   logic [DATA_W-1:0]         core_text;
   logic                      core_done = 1'b0;
   logic                      core_busy_n;
   logic [DATA_W-1:0]         cipher_text = '0;
   logic                      busy;

   prince_cfb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .chip_id_cfg(chip_id_cfg),
      .req_valid(req_valid), .req_encrypt(req_encrypt), .req_data(req_data),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
      .core_start(core_start), .core_encrypt(core_encrypt), .core_chip_id(core_chip_id),
      .core_text(core_text), .core_done(core_done), .core_busy_n(core_busy_n),
      .cipher_text(cipher_text), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_REQ-1:0] vld;
      logic               err;
      logic [DATA_W-1:0]  data;
   } exp_t;

   exp_t               sb[$];
   logic [NUM_REQ-1:0] exp_ack[$];
   int total = 0;
   int bad   = 0;
   int want  [NUM_REQ] = '{default: 0};
   int acked [NUM_REQ] = '{default: 0};
   int ack_total = 0, start_cnt = 0, jobs = 0;
   int cyc = 0, start_cyc = 0;

   // Core stand-in controls.
   int   lat = 4;
   bit   hang = 1'b0;
   bit   release_core = 1'b0;
   bit   force_busy = 1'b0;
   logic model_busy_n = 1'b1;
   logic pend = 1'b0;
   int   cnt = 0;
   logic [DATA_W-1:0] res = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Invertible stand-in for the prince_cfb transform.
   function automatic logic [15:0] model(input logic enc, input logic [15:0] d, input logic [15:0] k);
      logic [15:0] t;
      if (enc) begin
         t = d ^ k;
         return {t[12:0], t[15:13]} + 16'h1357;
      end
      t = d - 16'h1357;
      t = {t[2:0], t[15:3]};
      return t ^ k;
   endfunction

   always_comb begin
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) req_valid[i] = (want[i] > acked[i]);
   end
   assign core_busy_n = model_busy_n & ~force_busy;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (release_core) begin
         pend         <= 1'b0;
         model_busy_n <= 1'b1;
      end else if (core_start) begin
         pend         <= 1'b1;
         cnt          <= lat;
         model_busy_n <= 1'b0;
         res          <= model(core_encrypt, core_text, core_chip_id);
      end else if (pend && !hang) begin
         if (cnt <= 1) begin
            core_done    <= 1'b1;
            cipher_text  <= res;
            pend         <= 1'b0;
            model_busy_n <= 1'b1;
         end else begin
            cnt <= cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      exp_t        e;
      logic [NUM_REQ-1:0] ea;
      if (!rst) begin
         if (req_ack != '0) begin
            ack_total++;
            if (exp_ack.size() == 0) check_eq("ack_unexpected", 32'(req_ack), 32'd0);
            else begin
               ea = exp_ack.pop_front();
               check_eq("ack_order", 32'(req_ack), 32'(ea));
            end
            for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) acked[i]++;
            $display("ack  t=%0d req_ack=%b", cyc, req_ack);
         end
         if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
         end
         if (rsp_valid != '0) begin
            $display("rsp  t=%0d rsp_valid=%b err=%b data=%h", cyc, rsp_valid, rsp_err, rsp_data);
            if (sb.size() == 0) check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
               e = sb.pop_front();
               check_eq("rsp_valid", 32'(rsp_valid), 32'(e.vld));
               check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
               check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
               if (e.err) check_eq("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT + 2));
            end
         end else begin
            check_eq("rsp_err_idle", 32'(rsp_err), 32'd0);
         end
      end
   end

   task automatic issue(input int i, input logic enc, input logic [15:0] d, input bit expect_rsp);
      req_encrypt[i]           = enc;
      req_data[i*DATA_W +: DATA_W] = d;
      want[i]++;
      jobs++;
      exp_ack.push_back(NUM_REQ'(1) << i);
      if (expect_rsp) sb.push_back({NUM_REQ'(1) << i, 1'b0, model(enc, d, chip_id_cfg)});
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || exp_ack.size() != 0 || busy) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_eq("wait_bound", 32'(n >= max_cyc), 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      logic [15:0] ct;
      int s0, a0, n;
      // Reset state.
      repeat (2) @(negedge clk);
      check_eq("rst_req_ack", 32'(req_ack), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
      check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
      check_eq("rst_core_start", 32'(core_start), 32'd0);
      check_eq("rst_core_encrypt", 32'(core_encrypt), 32'd0);
      check_eq("rst_core_text", 32'(core_text), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_chip_id", 32'(core_chip_id), 32'h2020);
      rst = 1'b0;

      // Single encrypt job, then decrypt it back through a different requester.
      issue(0, 1'b1, 16'h7b0d, 1'b1);
      wait_done(100);
      ct = model(1'b1, 16'h7b0d, 16'h2020);
      lat = 7;
      req_encrypt[1] = 1'b0;
      req_data[1*DATA_W +: DATA_W] = ct;
      want[1]++; jobs++;
      exp_ack.push_back(4'b0010);
      sb.push_back({4'b0010, 1'b0, 16'h7b0d});
      wait_done(100);

      // Core reports busy: grant must wait.
      force_busy = 1'b1;
      lat = 2;
      issue(1, 1'b1, 16'hc35a, 1'b1);
      a0 = ack_total;
      repeat (8) @(negedge clk);
      check_eq("busy_blocks_ack", 32'(ack_total), 32'(a0));
      force_busy = 1'b0;
      wait_done(100);

      // Fairness from a fresh pointer with every requester asking.
      pulse_reset();
      issue(0, 1'b1, 16'h1111, 1'b1);
      issue(1, 1'b0, 16'h2222, 1'b1);
      issue(2, 1'b1, 16'h3333, 1'b1);
      issue(3, 1'b0, 16'h4444, 1'b1);
      issue(0, 1'b1, 16'h1111, 1'b1);
      wait_done(300);

      // Watchdog: core never finishes.
      hang = 1'b1;
      req_encrypt[2] = 1'b1;
      want[2]++; jobs++;
      exp_ack.push_back(4'b0100);
      sb.push_back({4'b0100, 1'b1, 16'h0000});
      wait_done(400);
      check_eq("idle_after_timeout", 32'(busy), 32'd0);
      @(negedge clk); release_core = 1'b1;
      @(negedge clk); release_core = 1'b0;

      // Reset while waiting on a hung core.
      s0 = start_cnt;
      issue(3, 1'b0, 16'h5a5a, 1'b0);
      n = 0;
      while (start_cnt == s0 && n < 20) begin @(negedge clk); n++; end
      check_eq("start_seen", 32'(start_cnt > s0), 32'd1);
      repeat (3) @(negedge clk);
      pulse_reset();
      check_eq("busy_after_rst", 32'(busy), 32'd0);
      issue(0, 1'b0, 16'h9e37, 1'b1);
      a0 = ack_total;
      repeat (8) @(negedge clk);
      check_eq("core_busy_after_rst", 32'(ack_total), 32'(a0));
      hang = 1'b0;
      wait_done(100);

      check_eq("ack_count", 32'(ack_total), 32'(jobs));
      check_eq("start_count", 32'(start_cnt), 32'(jobs));
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
